// File: rtl/lfsr_16bit_checker_if.sv
// Stream and status bundle for the 16-bit PRBS checker.
//   master: the stream source. Drives clear_i, valid_i and data_i, and observes the status.
//   slave : the checker. Consumes the stream and drives locked_o, err_o, err_cnt_o and
//           expected_o.
interface lfsr_16bit_checker_if #(
  parameter int unsigned ErrCntWidth = 16
);
  logic                   clear_i;
  logic                   valid_i;
  logic                   data_i;
  logic                   locked_o;
  logic                   err_o;
  logic [ErrCntWidth-1:0] err_cnt_o;
  logic                   expected_o;

  modport master (
    output clear_i, valid_i, data_i,
    input  locked_o, err_o, err_cnt_o, expected_o
  );

  modport slave (
    input  clear_i, valid_i, data_i,
    output locked_o, err_o, err_cnt_o, expected_o
  );
endinterface

// File: rtl/lfsr_16bit_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR stream (taps 15, 12, 5, 1).
// The checker works through three states:
//   SEED   : fills the history register from the incoming stream.
//   VERIFY : confirms that LockBits consecutive beats match the prediction.
//   LOCKED : runs a free-running reference and counts mismatches. It drops lock after LossErrs
//            consecutive mismatches.
// Ports:
//   clk_i  : clock.
//   rst_ni : asynchronous reset, active-low.
//   bus    : slave modport. It carries clear_i, valid_i and data_i in, and locked_o, err_o,
//            err_cnt_o (saturating) and expected_o (combinational prediction) out.
module lfsr_16bit_checker #(
  parameter int unsigned LockBits    = 16,
  parameter int unsigned LossErrs    = 4,
  parameter int unsigned ErrCntWidth = 16
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  lfsr_16bit_checker_if.slave bus
);

  localparam logic [7:0]             LockLast = 8'(LockBits - 1);
  localparam logic [7:0]             LossLast = 8'(LossErrs - 1);
  localparam logic [ErrCntWidth-1:0] CntOne   = ErrCntWidth'(1);

  typedef enum logic [1:0] {StSeed, StVerify, StLocked} state_e;

  state_e                 state_q;
  logic [15:0]            h_q;
  logic [4:0]             fill_q;
  logic [7:0]             match_q;
  logic [7:0]             cons_q;
  logic                   locked_q;
  logic                   err_q;
  logic [ErrCntWidth-1:0] err_cnt_q;

  logic pred;
  logic beat_ok;
  logic verify_ok;

  assign pred      = ~(h_q[15] ^ h_q[12] ^ h_q[5] ^ h_q[1]);
  assign beat_ok   = (bus.data_i == pred);
  // An all-ones history is the XNOR lock-up state and must never count towards lock.
  assign verify_ok = beat_ok && (h_q != 16'hFFFF);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StSeed;
      h_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      cons_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.clear_i) begin
        state_q   <= StSeed;
        h_q       <= '0;
        fill_q    <= '0;
        match_q   <= '0;
        cons_q    <= '0;
        locked_q  <= 1'b0;
        err_cnt_q <= '0;
      end else if (bus.valid_i) begin
        unique case (state_q)
          StSeed: begin
            h_q <= {h_q[14:0], bus.data_i};
            if (fill_q == 5'd15) begin
              state_q <= StVerify;
              fill_q  <= '0;
              match_q <= '0;
            end else begin
              fill_q <= fill_q + 5'd1;
            end
          end
          StVerify: begin
            h_q <= {h_q[14:0], bus.data_i};
            if (verify_ok) begin
              if (match_q == LockLast) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
                cons_q   <= '0;
              end
              match_q <= match_q + 8'd1;
            end else begin
              // Keep the history, but refill it before trusting it again.
              state_q <= StSeed;
              fill_q  <= '0;
            end
          end
          StLocked: begin
            // The reference free-runs on its own prediction, so a single flipped bit is
            // counted exactly once.
            h_q <= {h_q[14:0], pred};
            if (beat_ok) begin
              cons_q <= '0;
            end else begin
              err_q <= 1'b1;
              if (err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + CntOne;
              end
              if (cons_q == LossLast) begin
                state_q  <= StSeed;
                locked_q <= 1'b0;
                fill_q   <= '0;
                cons_q   <= '0;
              end else begin
                cons_q <= cons_q + 8'd1;
              end
            end
          end
          default: state_q <= StSeed;
        endcase
      end
    end
  end

  assign bus.locked_o   = locked_q;
  assign bus.err_o      = err_q;
  assign bus.err_cnt_o  = err_cnt_q;
  assign bus.expected_o = pred;

endmodule

// File: tb/tb_lfsr_16bit_checker.sv
// Bench for lfsr_16bit_checker. It drives two instances from one stream:
//   A : default parameters.
//   B : ErrCntWidth = 4 and LossErrs = 255, used for the saturation case.
// A table of stream phases is followed by a hand-written reset sequence. Expected err_o
// pulses are queued when a flipped beat is driven, and they are popped when the pulse is due.
module tb_lfsr_16bit_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic valid = 1'b0;
  logic data = 1'b0;

  always #5 clk = ~clk;

  lfsr_16bit_checker_if #(.ErrCntWidth(16)) bus_a ();
  lfsr_16bit_checker_if #(.ErrCntWidth(4))  bus_b ();

  assign bus_a.clear_i = clear;
  assign bus_a.valid_i = valid;
  assign bus_a.data_i  = data;
  assign bus_b.clear_i = clear;
  assign bus_b.valid_i = valid;
  assign bus_b.data_i  = data;

  lfsr_16bit_checker #(.LockBits(16), .LossErrs(4), .ErrCntWidth(16)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_a)
  );

  lfsr_16bit_checker #(.LockBits(16), .LossErrs(255), .ErrCntWidth(4)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_b)
  );

  localparam int ModeClean = 0;
  localparam int ModeFlip  = 1;
  localparam int ModeAlt   = 2;  // flip every even beat of the phase: isolated errors
  localparam int ModeOnes  = 3;
  localparam int ModeClear = 4;

  typedef struct {
    int n;
    int mode;
    bit gaps;
    bit lk_a;
    int cnt_a;
    bit lk_b;
    int cnt_b;
  } phase_t;

  localparam int NPh = 18;
  phase_t ph [NPh];

  logic [15:0] g = '0;  // generator state
  int beat = 0;
  int checks = 0;
  int failures = 0;
  int q_a[$];
  int q_b[$];

  function automatic logic gen_bit(input logic [15:0] s);
    return ~(s[15] ^ s[12] ^ s[5] ^ s[1]);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (beat %0d, t=%0t)", name, act, exp, beat, $time);
    end
  endtask

  // One clock cycle; outputs are sampled 1 time unit after the active edge.
  task automatic cycle(input logic v, input logic d, input logic c, input bit err_exp);
    bit had_beat;
    bit exp_a;
    bit exp_b;
    had_beat = v && !c;
    valid = v;
    data  = d;
    clear = c;
    if (had_beat) begin
      beat++;
      if (err_exp) begin
        q_a.push_back(beat);
        q_b.push_back(beat);
      end
    end
    @(posedge clk);
    #1;
    valid = 1'b0;
    clear = 1'b0;
    exp_a = 1'b0;
    exp_b = 1'b0;
    if (had_beat && q_a.size() > 0 && q_a[0] == beat) begin
      exp_a = 1'b1;
      void'(q_a.pop_front());
    end
    if (had_beat && q_b.size() > 0 && q_b[0] == beat) begin
      exp_b = 1'b1;
      void'(q_b.pop_front());
    end
    chk("err_a", int'(bus_a.err_o), int'(exp_a));
    chk("err_b", int'(bus_b.err_o), int'(exp_b));
  endtask

  task automatic gen_beat(input bit flip);
    logic b;
    b = gen_bit(g);
    chk("expected_a", int'(bus_a.expected_o), int'(b));
    chk("expected_b", int'(bus_b.expected_o), int'(b));
    cycle(1'b1, b ^ flip, 1'b0, flip);
    g = {g[14:0], b};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        n    mode       gaps lk_a cnt_a lk_b cnt_b
    ph[0]  = '{31,  ModeClean, 0, 0, 0,  0, 0};
    ph[1]  = '{1,   ModeClean, 0, 1, 0,  1, 0};
    ph[2]  = '{968, ModeClean, 0, 1, 0,  1, 0};
    ph[3]  = '{1,   ModeFlip,  0, 1, 1,  1, 1};
    ph[4]  = '{50,  ModeClean, 0, 1, 1,  1, 1};
    ph[5]  = '{3,   ModeFlip,  0, 1, 4,  1, 4};
    ph[6]  = '{1,   ModeFlip,  0, 0, 5,  1, 5};
    ph[7]  = '{31,  ModeClean, 0, 0, 5,  1, 5};
    ph[8]  = '{1,   ModeClean, 0, 1, 5,  1, 5};
    ph[9]  = '{100, ModeClean, 1, 1, 5,  1, 5};
    ph[10] = '{40,  ModeAlt,   0, 1, 25, 1, 15};
    ph[11] = '{4,   ModeAlt,   0, 1, 27, 1, 15};
    ph[12] = '{1,   ModeClear, 0, 0, 0,  0, 0};
    ph[13] = '{31,  ModeClean, 1, 0, 0,  0, 0};
    ph[14] = '{1,   ModeClean, 1, 1, 0,  1, 0};
    ph[15] = '{1,   ModeClear, 0, 0, 0,  0, 0};
    ph[16] = '{200, ModeOnes,  0, 0, 0,  0, 0};
    ph[17] = '{1,   ModeClear, 0, 0, 0,  0, 0};

    // Reset values.
    #3;
    chk("rst_locked_a", int'(bus_a.locked_o), 0);
    chk("rst_err_a", int'(bus_a.err_o), 0);
    chk("rst_cnt_a", int'(bus_a.err_cnt_o), 0);
    chk("rst_expected_a", int'(bus_a.expected_o), 1);
    chk("rst_cnt_b", int'(bus_b.err_cnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int p = 0; p < NPh; p++) begin
      for (int k = 0; k < ph[p].n; k++) begin
        if (ph[p].gaps) begin
          for (int j = 0; j < 3; j++) begin
            if ($urandom_range(1, 0) == 1) cycle(1'b0, 1'b0, 1'b0, 1'b0);
          end
        end
        case (ph[p].mode)
          ModeClean: gen_beat(1'b0);
          ModeFlip:  gen_beat(1'b1);
          ModeAlt:   gen_beat((k % 2) == 0);
          ModeOnes: begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0);
            chk("lockup_locked_a", int'(bus_a.locked_o), 0);
          end
          default: begin
            // A clear beat carries a 1 that must not reach the history.
            cycle(1'b1, 1'b1, 1'b1, 1'b0);
            g = '0;
          end
        endcase
      end
      if (ph[p].lk_a != bus_a.locked_o) $display("  phase %0d", p);
      chk("locked_a", int'(bus_a.locked_o), int'(ph[p].lk_a));
      chk("cnt_a", int'(bus_a.err_cnt_o), ph[p].cnt_a);
      chk("locked_b", int'(bus_b.locked_o), int'(ph[p].lk_b));
      chk("cnt_b", int'(bus_b.err_cnt_o), ph[p].cnt_b);
    end

    // Asynchronous reset while locked, in the cycle where err_o is high.
    for (int k = 0; k < 32; k++) gen_beat(1'b0);
    chk("seq_locked_a", int'(bus_a.locked_o), 1);
    gen_beat(1'b1);
    chk("seq_cnt_a", int'(bus_a.err_cnt_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_locked_a", int'(bus_a.locked_o), 0);
    chk("arst_err_a", int'(bus_a.err_o), 0);
    chk("arst_cnt_a", int'(bus_a.err_cnt_o), 0);
    chk("arst_expected_a", int'(bus_a.expected_o), 1);
    chk("arst_cnt_b", int'(bus_b.err_cnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    g = '0;
    @(posedge clk);
    #1;

    chk("pending_err_a", q_a.size(), 0);
    chk("pending_err_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_16bit_checker.md
# lfsr_16bit_checker

Receive-side counterpart of the 16-bit LFSR generator. It consumes the serial bit stream produced by the generator (XNOR taps 15, 12, 5, 1), self-synchronises to it, declares lock, and counts bit errors afterwards. It is used as a PRBS checker on links, memories and loopback paths driven by the generator, and for BIST.

## Interface
Parameters:
- `LockBits`, default 16: consecutive correctly predicted beats required after seeding to declare lock (1..255).
- `LossErrs`, default 4: consecutive mispredicted beats while locked that drop lock (1..255).
- `ErrCntWidth`, default 16: width of the saturating error counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous restart. Returns to SEED and zeroes history and all counters.
- `valid_i`  in  1  `data_i` carries a stream bit this cycle.
- `data_i`  in  1  received bit. This is the generator's new LSB after each enabled shift.
- `locked_o`  out  1  checker is in LOCKED.
- `err_o`  out  1  one-cycle pulse: the previous beat mismatched while LOCKED.
- `err_cnt_o`  out  ErrCntWidth  saturating count of mismatches while LOCKED.
- `expected_o`  out  1  predicted bit for the next beat: !(h[15]^h[12]^h[5]^h[1]).

## Operation
- 16-bit history register `h`. A beat shifts in at LSB: h <= {h[14:0], bit}.
- Prediction `p` = XNOR of h[15], h[12], h[5], h[1]. A beat matches when data_i == p.
- States: SEED, VERIFY, LOCKED.
- SEED:
  - Every beat shifts in data_i.
  - A 5-bit fill counter counts beats; no comparison is made.
  - After the 16th beat, go to VERIFY with the match counter at 0.
- VERIFY:
  - Every beat shifts in data_i.
  - A beat matches only if it equals `p` and h != 16'hFFFF. The all-ones state is the XNOR lock-up state and never counts as a match.
  - On a match, increment the match counter. When it reaches LockBits, go to LOCKED.
  - On a mismatch, go to SEED with the fill counter at 0. The history is kept but refilled.
- LOCKED:
  - Every beat shifts in `p`, not data_i. The reference is free-running, so one flipped bit counts exactly once (no tap error multiplication).
  - On a mismatch: pulse err_o, increment err_cnt_o (saturating at all-ones), increment the consecutive-error counter.
  - On a match: clear the consecutive-error counter.
  - When the consecutive-error counter reaches LossErrs, go to SEED with the fill counter at 0. err_cnt_o is retained.
- err_cnt_o is cleared only by reset or clear_i. It never wraps.
- When valid_i = 0: no state, counter or history change, and err_o = 0.

## Timing
- All outputs are registered except expected_o, which is combinational from `h`.
- Reset values: state SEED, h = 0, all counters 0, locked_o = 0, err_o = 0, err_cnt_o = 0, so expected_o = 1.
- With a clean stream from SEED, locked_o rises on the clock edge that samples beat 16+LockBits. It is visible the following cycle.
- err_o is high for exactly one cycle, the cycle after the erroneous beat's edge. err_cnt_o updates on the same edge.
- locked_o falls on the edge that samples the LossErrs-th consecutive error. err_o also pulses for that beat.
- clear_i has priority over valid_i in the same cycle. The beat is discarded and the next cycle is SEED with everything zeroed.
- Reset asserted mid-operation forces the reset values immediately, asynchronously.
- Throughput is one beat per cycle, with no back-pressure.

## Test plan
- Clean lock:
  - Stimulus: generator with SEED 0x0000, en every cycle (bits start 1,1,0,...), defaults.
  - Required: locked_o = 1 the cycle after beat 32, err_cnt_o = 0 after 1000 beats.
- Single error:
  - Stimulus: locked, flip beat 100.
  - Required: one err_o pulse, err_cnt_o = 1, locked_o stays 1, no further errors.
- Loss and relock:
  - Stimulus: flip 4 consecutive beats while locked.
  - Required: err_cnt_o = 4, locked_o = 0 after the 4th, relock 32 clean beats later, err_cnt_o still 4.
- Lock-up input:
  - Stimulus: data_i = 1 constantly for 200 beats.
  - Required: locked_o never asserts, err_cnt_o = 0.
- Saturation:
  - Stimulus: ErrCntWidth = 4, LossErrs = 255, 20 isolated flips while locked.
  - Required: err_cnt_o = 15 and holds.
- Gaps and clear:
  - Stimulus: random valid_i gaps (50%) during lock; then clear_i together with valid_i.
  - Required: lock at beat 32 counting valid beats only; after clear, locked_o = 0 and err_cnt_o = 0, and the coincident beat is ignored.
